btn_event_ctrl: RTL and testbench
=================================

Name: btn_event_ctrl

Overview:
- Bus-programmable debounce controller for the board's button/switch inputs.
- Synchronises and debounces NIN inputs using a single shared lockout timer whose hold time is set by software.
- Each committed change of the debounced vector is queued as an event word in a small FIFO, with an interrupt while events are pending.
- Sits between the raw pad inputs and the CPU's peripheral bus.

Parameters:
- NIN, 21, number of inputs (1..24).
- LGWAIT, 17, width of the lockout timer and WAIT register.
- LGFIFO, 4, log2 of event FIFO depth (1..5).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_in  in  NIN  raw asynchronous inputs
- i_wb_stb  in  1  bus strobe, one cycle per request
- i_wb_we  in  1  1 = write
- i_wb_addr  in  2  register select
- i_wb_data  in  32  write data
- o_wb_ack  out  1  ack, exactly one cycle after i_wb_stb
- o_wb_data  out  32  read data, valid with o_wb_ack
- o_int  out  1  interrupt: FIFO non-empty AND int_en
- o_debounced  out  NIN  current debounced state

Behaviour:
- Reset values (async, on i_reset): q_in, r_in, r_last, o_debounced = 0; WAIT = all ones; timer = all ones; FIFO empty; overflow = 0; int_en = 0; seq = 0; o_wb_ack = 0; o_wb_data = 0; o_int = 0.
- Sync: two-flop chain i_in -> q_in -> r_in.
- Each edge, in priority order:
  - If r_last != r_in: r_last <= r_in; timer <= WAIT.
  - Else if timer == 0 ("commit"): o_debounced <= r_last. If r_last != o_debounced, push event.
  - Else: timer <= timer - 1.
- Latency: i_in stable from edge k gives o_debounced updated at edge k+WAIT+3. The event is pushed on the same edge; count/o_int reflect it on the following edge.
- Any change during lockout restarts the timer, so no event is generated for bounces.
- A WAIT write mid-count does not alter the running timer; it takes effect at the next reload.
- Event word: [31:24] sequence field (see Optional Feature); [23:NIN] zero; [NIN-1:0] new o_debounced value.
- FIFO depth 2^LGFIFO.
  - Push when full: event dropped, overflow <= 1 (sticky); seq still increments.
  - Pop when empty: returns 0, no state change.
  - Simultaneous push and pop: both occur, count unchanged, order preserved. If the FIFO is full, this push is accepted because a pop occurs on the same edge.
- Registers (by i_wb_addr):
  - 0 STATUS
    - Read: [31] overflow, [30] non-empty, [29] int_en, [LGFIFO:0] count, rest 0.
    - Write: bit31=1 clears overflow; bit29 loads int_en; other bits ignored.
  - 1 EVENT
    - Read returns FIFO head and pops it (pop occurs only on read strobe).
    - Write ignored.
  - 2 WAIT
    - Read: [LGWAIT-1:0] WAIT.
    - Write: loads WAIT from i_wb_data[LGWAIT-1:0].
  - 3 STATE
    - Read: zero-extended o_debounced.
    - Write ignored.
- Bus timing:
  - o_wb_ack <= i_wb_stb every edge.
  - o_wb_data registered on the strobe edge; holds its value otherwise.
  - Read data reflects state before any same-edge push.
- o_int: registered, = (count != 0) & int_en, one edge after count changes.

Optional Feature:
- Macro: BTNCTL_SEQNUM_EN.
- Defined: 8-bit seq counter increments on every attempted push (including dropped ones), wrapping 255 -> 0. Event bits [31:24] = seq value at push, so software can detect lost events by gaps.
- Undefined: no seq counter; event bits [31:24] = 0.

Test Plan:
- Reset: assert i_reset mid-run -> all outputs 0 immediately; WAIT reads 0x1FFFF; STATUS reads 0.
- WAIT=4, int_en=1, i_in[0] 0->1 held -> o_debounced[0]=1 exactly 7 edges after the first sampling edge; STATUS count=1; o_int=1. EVENT read -> 0x00000001 (SEQNUM_EN: 0x00000001, seq 0); o_int=0 next edge.
- WAIT=4, toggle i_in[3] every 3 cycles for 30 cycles, then return to 0 -> no event, o_debounced unchanged, count 0.
- LGFIFO=4, 17 committed changes without reads -> count=16, overflow=1, 17th lost. SEQNUM_EN: 16th entry seq=15. Write STATUS 0x80000000 -> overflow=0, count=16.
- FIFO holding 3 entries: EVENT read strobe on the same edge as a commit -> count stays 3; read returns the oldest entry; new entry is last.
- EVENT read with FIFO empty -> o_wb_data=0, ack after 1 cycle, count 0, overflow unchanged.

Source files
------------

// File: rtl/btn_event_ctrl.sv
// Debounce controller: syncs NIN raw inputs, debounces them with one shared lockout timer,
// and queues every committed change as an event word. Optional macro: BTNCTL_SEQNUM_EN.
module btn_event_ctrl #(
    parameter int NIN    = 21,
    parameter int LGWAIT = 17,
    parameter int LGFIFO = 4
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic [NIN-1:0] i_in,
    input  logic           i_wb_stb,
    input  logic           i_wb_we,
    input  logic [1:0]     i_wb_addr,
    input  logic [31:0]    i_wb_data,
    output logic           o_wb_ack,
    output logic [31:0]    o_wb_data,
    output logic           o_int,
    output logic [NIN-1:0] o_debounced
);
    localparam int DEPTH = 1 << LGFIFO;

    logic [NIN-1:0]    q_in, r_in, r_last;
    logic [LGWAIT-1:0] wait_r, timer;
    logic [31:0]       mem [DEPTH];
    logic [LGFIFO-1:0] wr_ptr, rd_ptr;
    logic [LGFIFO:0]   count;
    logic              overflow, int_en;
    logic              commit, push, pop, full, push_ok;
    logic [31:0]       ev_word, status_word, rdata;
`ifdef BTNCTL_SEQNUM_EN
    logic [7:0]        seq;
`endif

    // Bus: single-cycle strobe; ack and read data are registered on the strobe edge.
    always_comb begin
        commit  = (r_last == r_in) && (timer == '0);
        push    = commit && (r_last != o_debounced);
        pop     = i_wb_stb && !i_wb_we && (i_wb_addr == 2'd1) && (count != '0);
        full    = (count == (LGFIFO+1)'(DEPTH));
        push_ok = push && (!full || pop);

        ev_word = '0;
        ev_word[NIN-1:0] = r_last;
`ifdef BTNCTL_SEQNUM_EN
        ev_word[31:24] = seq;
`endif

        status_word = '0;
        status_word[31] = overflow;
        status_word[30] = (count != '0);
        status_word[29] = int_en;
        status_word[LGFIFO:0] = count;

        rdata = '0;
        case (i_wb_addr)
            2'd0: rdata = status_word;
            2'd1: rdata = (count != '0) ? mem[rd_ptr] : 32'd0;
            2'd2: rdata[LGWAIT-1:0] = wait_r;
            default: rdata[NIN-1:0] = o_debounced;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            q_in        <= '0;
            r_in        <= '0;
            r_last      <= '0;
            o_debounced <= '0;
            wait_r      <= '1;
            timer       <= '1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            int_en      <= 1'b0;
            o_wb_ack    <= 1'b0;
            o_wb_data   <= '0;
            o_int       <= 1'b0;
        end else begin
            q_in <= i_in;
            r_in <= q_in;

            if (r_last != r_in) begin
                r_last <= r_in;
                timer  <= wait_r;
            end else if (timer == '0) begin
                o_debounced <= r_last;
            end else begin
                timer <= timer - LGWAIT'(1);
            end

            if (push_ok) wr_ptr <= wr_ptr + LGFIFO'(1);
            if (pop)     rd_ptr <= rd_ptr + LGFIFO'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (LGFIFO+1)'(1);
                2'b01:   count <= count - (LGFIFO+1)'(1);
                default: count <= count;
            endcase

            if (i_wb_stb && i_wb_we) begin
                case (i_wb_addr)
                    2'd0: begin
                        if (i_wb_data[31]) overflow <= 1'b0;
                        int_en <= i_wb_data[29];
                    end
                    2'd2: wait_r <= i_wb_data[LGWAIT-1:0];
                    default: ;
                endcase
            end
            // A dropped push must win over a same-edge clear so the loss is never hidden.
            if (push && !push_ok) overflow <= 1'b1;

            o_wb_ack <= i_wb_stb;
            if (i_wb_stb) o_wb_data <= rdata;
            o_int <= (count != '0) && int_en;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= ev_word;
    end

`ifdef BTNCTL_SEQNUM_EN
    // Sequence advances on every attempted push so dropped events leave a visible gap.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) seq <= 8'd0;
        else if (push) seq <= seq + 8'd1;
    end
`endif
endmodule

// File: tb/tb_btn_event_ctrl.sv
// Self-checking bench for btn_event_ctrl: table-driven register vectors plus
// hand-written debounce, overflow, simultaneous push/pop and reset sequences.
module tb_btn_event_ctrl;
    localparam int NIN = 21, LGWAIT = 17, LGFIFO = 4;

    logic            clk, rst;
    logic [NIN-1:0]  in_v;
    logic            stb, we;
    logic [1:0]      addr;
    logic [31:0]     wdata;
    logic            ack;
    logic [31:0]     rdata;
    logic            irq;
    logic [NIN-1:0]  deb;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd;

    btn_event_ctrl #(.NIN(NIN), .LGWAIT(LGWAIT), .LGFIFO(LGFIFO)) dut (
        .i_clk(clk), .i_reset(rst), .i_in(in_v), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_ack(ack), .o_wb_data(rdata),
        .o_int(irq), .o_debounced(deb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[14];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ev_word(input int s, input int val);
        logic [31:0] w;
        w = 32'(val) & 32'h00FF_FFFF;
`ifdef BTNCTL_SEQNUM_EN
        w[31:24] = 8'(s);
`endif
        return w;
    endfunction

    // All bus tasks start and end on a falling edge.
    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        stb = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        stb = 1'b0; we = 1'b0;
        check32("write_ack", {31'd0, ack}, 32'd1);
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
        stb = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        stb = 1'b0;
        check32("read_ack", {31'd0, ack}, 32'd1);
        d = rdata;
    endtask

    task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(a, d);
        check32(name, d, exp);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 2'd0, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, 2'd2, 32'h0,         32'h0001_FFFF};
        vecs[2]  = '{1'b0, 2'd3, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 2'd1, 32'h0,         32'h0};
        vecs[4]  = '{1'b1, 2'd2, 32'hFFFE_0005, 32'h0};
        vecs[5]  = '{1'b0, 2'd2, 32'h0,         32'h0000_0005};
        vecs[6]  = '{1'b1, 2'd2, 32'h4,         32'h0};
        vecs[7]  = '{1'b0, 2'd2, 32'h0,         32'h0000_0004};
        vecs[8]  = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0};
        vecs[9]  = '{1'b0, 2'd0, 32'h0,         32'h2000_0000};
        vecs[10] = '{1'b1, 2'd1, 32'h123,       32'h0};
        vecs[11] = '{1'b1, 2'd3, 32'hFFFF,      32'h0};
        vecs[12] = '{1'b0, 2'd0, 32'h0,         32'h2000_0000};
        vecs[13] = '{1'b0, 2'd3, 32'h0,         32'h0};

        rst = 1'b1; in_v = '0; stb = 1'b0; we = 1'b0; addr = 2'd0; wdata = '0;
        repeat (3) @(negedge clk);
        check32("reset_deb", 32'(deb), 32'd0);
        check32("reset_int", {31'd0, irq}, 32'd0);
        check32("reset_ack", {31'd0, ack}, 32'd0);
        check32("reset_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Register map vectors; leaves WAIT=4 and int_en=1.
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].we) wb_write(vecs[i].addr, vecs[i].wdata);
            else read_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // Latency: change seen at sampling edge k, committed at edge k+7.
        in_v[0] = 1'b1;
        repeat (7) @(negedge clk);
        check32("lat_before", 32'(deb), 32'd0);
        @(negedge clk);
        check32("lat_commit", 32'(deb), 32'd1);
        check32("lat_int_early", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check32("lat_int", {31'd0, irq}, 32'd1);
        read_chk("lat_status", 2'd0, 32'h6000_0001);
        read_chk("lat_event", 2'd1, ev_word(0, 1));
        @(negedge clk);
        check32("lat_int_clear", {31'd0, irq}, 32'd0);

        // Bounce: toggling every 3 cycles never lets the lockout expire.
        for (int t = 0; t < 10; t++) begin
            in_v[3] = ~in_v[3];
            repeat (3) @(negedge clk);
        end
        repeat (15) @(negedge clk);
        check32("bounce_deb", 32'(deb), 32'd1);
        read_chk("bounce_status", 2'd0, 32'h2000_0000);

        // Mid-run reset.
        in_v = '0;
        rst = 1'b1;
        #1;
        check32("mid_reset_deb", 32'(deb), 32'd0);
        check32("mid_reset_int", {31'd0, irq}, 32'd0);
        check32("mid_reset_ack", {31'd0, ack}, 32'd0);
        check32("mid_reset_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        read_chk("mid_reset_wait", 2'd2, 32'h0001_FFFF);
        read_chk("mid_reset_status", 2'd0, 32'h0);
        wb_write(2'd2, 32'd4);

        // Overflow: 17 committed changes into a 16-deep FIFO.
        for (int j = 1; j <= 17; j++) begin
            in_v = NIN'(j);
            repeat (10) @(negedge clk);
            if (j <= 16) exp_q.push_back(ev_word(j - 1, j));
        end
        check32("ovf_deb", 32'(deb), 32'd17);
        check32("ovf_int_off", {31'd0, irq}, 32'd0);
        read_chk("ovf_status", 2'd0, 32'hC000_0010);
        wb_write(2'd0, 32'h8000_0000);
        read_chk("ovf_cleared", 2'd0, 32'h4000_0010);
        for (int i = 0; i < 13; i++) begin
            wb_read(2'd1, rd);
            check32($sformatf("drain%0d", i), rd, exp_q.pop_front());
        end
        read_chk("three_left", 2'd0, 32'h4000_0003);

        // Commit on the same edge as an EVENT read strobe.
        in_v = NIN'(18);
        repeat (7) @(negedge clk);
        wb_read(2'd1, rd);
        check32("simul_head", rd, exp_q.pop_front());
        exp_q.push_back(ev_word(17, 18));
        read_chk("simul_count", 2'd0, 32'h4000_0003);
        for (int i = 0; i < 3; i++) begin
            wb_read(2'd1, rd);
            check32($sformatf("tail%0d", i), rd, exp_q.pop_front());
        end

        // Empty pop returns zero and changes nothing.
        read_chk("empty_event", 2'd1, 32'h0);
        read_chk("empty_status", 2'd0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
